// File: rtl/cpa3_pkg.sv
// Shared types and constants for the sequential 3-row carry-propagate adder.
package cpa3_pkg;

  localparam int unsigned CPA3_W_DEF   = 144;
  localparam int unsigned CPA3_SEG_DEF = 36;

  typedef enum logic [1:0] {
    IDLE,
    CSA,
    ADD,
    DONE
  } cpa3_state_e;

  function automatic int unsigned cpa3_nseg(input int unsigned w, input int unsigned seg);
    return w / seg;
  endfunction

endpackage

// File: rtl/cpa3_seg_adder.sv
// One segment of the carry-propagate adder: WIDTH-bit add with carry in/out.
module cpa3_seg_adder #(
  parameter int unsigned WIDTH = 36
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  assign {cout, sum} = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};

endmodule

// File: rtl/cpa_3row_seq.sv
// Sequential CPA: result = row0 + 2*row1 + 4*row2 via one 3:2 step and NSEG segment adds.
// Optional overflow flag (out_ovf, W+3-bit datapath) enabled by defining CPA3_OVF_EN.
module cpa_3row_seq
  import cpa3_pkg::*;
#(
  parameter int unsigned W   = CPA3_W_DEF,
  parameter int unsigned SEG = CPA3_SEG_DEF
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] row0,
  input  logic [W-1:0] row1,
  input  logic [W-1:0] row2,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] result
`ifdef CPA3_OVF_EN
  ,
  output logic         out_ovf
`endif
);

  localparam int unsigned NSEG = cpa3_nseg(W, SEG);
`ifdef CPA3_OVF_EN
  localparam int unsigned EXT = 3;
`else
  localparam int unsigned EXT = 0;
`endif
  localparam int unsigned DW       = W + EXT;
  localparam int unsigned AW       = SEG + EXT;
  localparam int unsigned SIW      = (NSEG > 1) ? $clog2(NSEG) : 1;
  localparam logic [SIW-1:0] LAST_IDX = SIW'(NSEG - 1);
  localparam int unsigned TOP_LSB  = (NSEG - 1) * SEG;

  if (W % SEG != 0) begin : g_w_seg_check
    $error("cpa_3row_seq: W must be a multiple of SEG");
  end

  cpa3_state_e state, state_n;

  logic [DW-1:0]  a_in, b_in, c_in;
  logic [DW-1:0]  a_q, b_q, c_q;
  logic [DW-1:0]  s_n, k_n, maj;
  logic [DW-1:0]  s_q, k_q;
  logic [SIW-1:0] seg_idx;
  logic           carry;
  logic [AW-1:0]  op_s, op_k, seg_sum;
  logic           seg_cout, seg_carry;
  logic           last_seg;

  // Bits shifted past the datapath width are dropped by the size casts.
  always_comb begin
    a_in = DW'(row0);
    b_in = DW'({row1, 1'b0});
    c_in = DW'({row2, 2'b00});
  end

  always_comb begin
    maj = (a_q & b_q) | (a_q & c_q) | (b_q & c_q);
    s_n = a_q ^ b_q ^ c_q;
    k_n = DW'({maj, 1'b0});
  end

  assign last_seg = (seg_idx == LAST_IDX);

  // Lower slices are zero-extended to the adder width; the top slice carries the extra bits.
  always_comb begin
    op_s = '0;
    op_k = '0;
    if (last_seg) begin
      op_s = s_q[TOP_LSB +: AW];
      op_k = k_q[TOP_LSB +: AW];
    end else begin
      op_s[SEG-1:0] = s_q[seg_idx*SEG +: SEG];
      op_k[SEG-1:0] = k_q[seg_idx*SEG +: SEG];
    end
  end

  cpa3_seg_adder #(
    .WIDTH(AW)
  ) u_seg_adder (
    .a   (op_s),
    .b   (op_k),
    .cin (carry),
    .sum (seg_sum),
    .cout(seg_cout)
  );

`ifdef CPA3_OVF_EN
  logic seg_ovf;
  assign seg_carry = seg_sum[SEG];
  assign seg_ovf   = |{seg_cout, seg_sum[AW-1:SEG]};
`else
  assign seg_carry = seg_cout;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  always_comb begin
    state_n = state;
    case (state)
      IDLE:    if (in_valid) state_n = CSA;
      CSA:     state_n = ADD;
      ADD:     if (last_seg) state_n = DONE;
      DONE:    if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q     <= '0;
      b_q     <= '0;
      c_q     <= '0;
      s_q     <= '0;
      k_q     <= '0;
      seg_idx <= '0;
      carry   <= 1'b0;
      result  <= '0;
`ifdef CPA3_OVF_EN
      out_ovf <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_q <= a_in;
            b_q <= b_in;
            c_q <= c_in;
          end
        end
        CSA: begin
          s_q     <= s_n;
          k_q     <= k_n;
          seg_idx <= '0;
          carry   <= 1'b0;
        end
        ADD: begin
          result[seg_idx*SEG +: SEG] <= seg_sum[SEG-1:0];
          carry                      <= seg_carry;
          seg_idx                    <= last_seg ? '0 : seg_idx + 1'b1;
`ifdef CPA3_OVF_EN
          if (last_seg) out_ovf <= seg_ovf;
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cpa_3row_seq.sv
// Scoreboard bench for cpa_3row_seq: arithmetic reference model, queue of expected results,
// negedge monitor comparing on each output handshake.
module tb_cpa_3row_seq;

  localparam int unsigned W    = 144;
  localparam int unsigned SEG  = 36;
  localparam int unsigned NSEG = W / SEG;
  localparam int unsigned XW   = W + 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] row0 = '0;
  logic [W-1:0] row1 = '0;
  logic [W-1:0] row2 = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
`ifdef CPA3_OVF_EN
  logic         out_ovf;
`endif

  cpa_3row_seq #(
    .W  (W),
    .SEG(SEG)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .row0     (row0),
    .row1     (row1),
    .row2     (row2),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result)
`ifdef CPA3_OVF_EN
    ,
    .out_ovf  (out_ovf)
`endif
  );

  typedef struct {
    logic [W-1:0] res;
    logic         ovf;
    int unsigned  acc;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int unsigned ncmp = 0;
  int unsigned nerr = 0;
  int unsigned cyc  = 0;
  int          rdy_mode = 1;
  logic        prev_ov = 1'b0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [XW-1:0] act, input logic [XW-1:0] exp);
    ncmp++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %0h, required %0h", nm, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [W-1:0] r0, input logic [W-1:0] r1,
                                 input logic [W-1:0] r2, input int unsigned acc);
    exp_t          e;
    logic [XW-1:0] full;
    full  = XW'(r0) + (XW'(r1) << 1) + (XW'(r2) << 2);
    e.res = full[W-1:0];
    e.ovf = |full[XW-1:W];
    e.acc = acc;
    return e;
  endfunction

  function automatic logic [W-1:0] rnd_row();
    logic [W-1:0] v = '0;
    for (int i = 0; i < 5; i++) v = {v[W-33:0], 32'($urandom)};
    return v;
  endfunction

  // Consumer: drives out_ready, then checks latency and popped results.
  always @(negedge clk) begin
    case (rdy_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
    if (!rst) begin
      if (out_valid && !prev_ov && sb.size() > 0)
        chk("latency", XW'(cyc - sb[0].acc), XW'(NSEG + 1));
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          ncmp++;
          nerr++;
          $display("FAIL unexpected_output: got result %0h, required no output", result);
        end else begin
          mon_e = sb.pop_front();
          chk("result", XW'(result), XW'(mon_e.res));
`ifdef CPA3_OVF_EN
          chk("out_ovf", XW'(out_ovf), XW'(mon_e.ovf));
`endif
        end
      end
    end
    prev_ov = out_valid;
  end

  task automatic send(input logic [W-1:0] r0, input logic [W-1:0] r1, input logic [W-1:0] r2);
    int t = 0;
    @(negedge clk);
    while (!in_ready && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      ncmp++;
      nerr++;
      $display("FAIL accept_timeout: in_ready 0 after %0d cycles, required 1", t);
      return;
    end
    row0     = r0;
    row1     = r1;
    row2     = r2;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    sb.push_back(model(r0, r1, r2, cyc));
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (sb.size() != 0) begin
      ncmp++;
      nerr++;
      $display("FAIL drain_timeout: %0d results pending, required 0", sb.size());
      sb.delete();
    end
  endtask

  task automatic wait_valid();
    int t = 0;
    while (!out_valid && t < 100) begin
      @(negedge clk);
      t++;
    end
    if (!out_valid) begin
      ncmp++;
      nerr++;
      $display("FAIL valid_timeout: out_valid 0 after %0d cycles, required 1", t);
    end
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, required completion");
    $fatal(1);
  end

  initial begin
    logic [W-1:0] ones;
    logic [W-1:0] one;
    logic [W-1:0] msb;
    logic [W-1:0] held;
    logic [W-1:0] a, b, c;
    ones = '1;
    one  = W'(1);
    msb  = '0;
    msb[W-1] = 1'b1;

    // Reset held for two cycles
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", XW'(in_ready), XW'(1));
    chk("rst_out_valid", XW'(out_valid), XW'(0));
    chk("rst_result", XW'(result), XW'(0));
    rst = 1'b0;

    send(one, one, one);
    drain();

    // Carry ripples across every segment
    send(ones, one, '0);
    drain();

    // Backpressure: result held, no acceptance while DONE
    rdy_mode = 0;
    send(rnd_row(), rnd_row(), rnd_row());
    @(negedge clk);
    wait_valid();
    held = result;
    repeat (10) begin
      @(negedge clk);
      in_valid = 1'b1;
      row0 = rnd_row();
      row1 = rnd_row();
      row2 = rnd_row();
      chk("bp_in_ready", XW'(in_ready), XW'(0));
      chk("bp_out_valid", XW'(out_valid), XW'(1));
      chk("bp_result_hold", XW'(result), XW'(held));
    end
    @(negedge clk);
    in_valid = 1'b0;
    rdy_mode = 1;
    drain();

    // Reset in the middle of ADD
    send(rnd_row(), rnd_row(), rnd_row());
    repeat (3) @(negedge clk);
    rst = 1'b1;
    void'(sb.pop_back());
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_in_ready", XW'(in_ready), XW'(1));
    chk("midrst_out_valid", XW'(out_valid), XW'(0));
    chk("midrst_result", XW'(result), XW'(0));
    send(W'(5), W'(3), W'(2));
    drain();

    // row2 MSB is shifted out of the W-bit result
    send('0, '0, msb);
    drain();

    // Randomized traffic with random consumer stalls
    rdy_mode = 2;
    for (int n = 0; n < 40; n++) begin
      case ($urandom_range(0, 3))
        0: begin a = ones; b = ones; c = ones; end
        1: begin a = ones; b = W'($urandom_range(0, 3)); c = W'($urandom_range(0, 1)); end
        default: begin a = rnd_row(); b = rnd_row(); c = rnd_row(); end
      endcase
      send(a, b, c);
    end
    drain();
    rdy_mode = 1;
    repeat (4) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", ncmp, nerr);
    $finish;
  end

endmodule

// File: doc/cpa_3row_seq.md
# cpa_3row_seq

Sequential carry-propagate adder that consumes the three weighted rows produced by the 7:3 column-compression stage of the 72x72 Karatsuba multiplier. It forms the final binary product as row0 + 2·row1 + 4·row2. It first applies one internal 3:2 carry-save step, then resolves carries over a fixed number of segment cycles. Valid/ready handshakes are used on both sides, so it sits between the compression tree and the product output register.

## Interface
- W, default 144: row and result width (72x72 product).
- SEG, default 36: segment width added per cycle; W % SEG == 0 is required (elaboration-time check); NSEG = W/SEG.
- clk  input  1  clock, all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- in_valid  input  1  row triple presented.
- in_ready  output  1  block can accept a triple.
- row0  input  W  column bits of weight 1 (compressor out0 vector).
- row1  input  W  column bits of weight 2 (out1 vector, unshifted).
- row2  input  W  column bits of weight 4 (out2 vector, unshifted).
- out_valid  output  1  result held and valid.
- out_ready  input  1  consumer accepts result.
- result  output  W  (row0 + (row1<<1) + (row2<<2)) mod 2^W.
- out_ovf  output  1  present only with CPA3_OVF_EN (see Configuration).

## Operation
- Alignment is internal: row1 is shifted left by 1 and row2 by 2; bits shifted past W-1 are discarded, except when CPA3_OVF_EN is defined.
- FSM states: IDLE, CSA, ADD, DONE.
- IDLE: in_ready=1; on in_valid&&in_ready, capture the aligned rows and go to CSA.
- CSA: one cycle. s = a^b^c; k = maj(a,b,c)<<1 (truncated to W). Register s and k, clear seg_idx and carry, go to ADD.
- ADD: each cycle adds slice seg_idx of s and k plus carry, writes result[seg_idx*SEG +: SEG], latches the carry-out and increments seg_idx. After slice NSEG-1, go to DONE.
- DONE: out_valid=1; result and out_ovf are held stable. On out_ready, go to IDLE.
- in_ready=0 in CSA, ADD and DONE. There is no acceptance in the same cycle as the out_ready handshake; IDLE is always revisited.
- Arithmetic is unsigned, modulo 2^W.
- Reset (any state, including mid-ADD) forces IDLE:
  - in_ready=1 in the cycle after reset,
  - out_valid=0, result=0, out_ovf=0,
  - seg_idx=0, carry=0.
  - The partial result is discarded.
- in_valid while not ready is ignored; the upstream must hold its data.

## Timing
- Acceptance edge = cycle 0. CSA registers load at edge 1. ADD edges run 2..NSEG+1. out_valid is high from edge NSEG+1 (NSEG+1 cycles after acceptance; 5 with defaults).
- Throughput: one result per NSEG+3 cycles minimum (out_ready held high).
- result is updated only in ADD; upper slices may show stale bits before DONE, and consumers sample only when out_valid=1.
- out_ready is ignored outside DONE.

## Configuration
- CPA3_OVF_EN defined:
  - The internal datapath is widened to W+3 bits; the top segment is SEG+3 wide. Shifted-out row bits and the majority MSB are retained.
  - out_ovf = |(bits W+2..W of the exact sum), held in DONE.
  - Latency is unchanged.
- CPA3_OVF_EN undefined: the out_ovf port and the extra bits do not exist; the sum is truncated.

## Structure
- Package cpa3_pkg:
  - FSM state enum (IDLE, CSA, ADD, DONE),
  - NSEG derivation function,
  - default W/SEG constants.
- Sub-module cpa3_seg_adder: SEG-bit (parameterised width) adder with cin and cout, instantiated once and indexed by seg_idx.

## Test plan
- Reset then idle: after rst is held for 2 cycles -> in_ready=1, out_valid=0, result=0.
- row0=1, row1=1, row2=1 -> result=7 at edge 5 after acceptance; out_valid stays high until out_ready.
- Full carry ripple: row0=all ones, row1=0, row2=0 with row0 low bit set, then row1=1 -> result=(2^144-1)+2 mod 2^144 = 1. This checks carry crossing all 4 segments.
- Backpressure: out_ready=0 for 10 cycles after done -> result stable and in_ready=0 throughout; in_valid pulses during that window are not accepted.
- Reset mid-ADD: assert rst at edge 3 -> next cycle IDLE, result=0; a following triple (5, 3, 2) gives 5+6+8=19.
- With CPA3_OVF_EN: row2 MSB=1, others 0 -> result=0, out_ovf=1. Without the macro: result=0 and no port.
